// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - command, image ROM and image RAM signal bundle for lcd_ctrl
interface lcd_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic              IROM_rd;
    logic [5:0]        IROM_A;
    logic [DATA_W-1:0] IROM_Q;
    logic              IRAM_valid;
    logic [5:0]        IRAM_A;
    logic [DATA_W-1:0] IRAM_D;
    logic              busy;
    logic              done;

    // Environment side: host commands plus the ROM/RAM models
    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
    );

    // Controller side
    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
    );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - 8x8 image buffer with 2x2 block commands; LCD_AVG_ROUND_EN selects rounded average
module lcd_ctrl #(
    parameter int DATA_W = 8,
    parameter int INIT_X = 4,
    parameter int INIT_Y = 4
) (
    input  logic       clk,
    input  logic       reset,
    lcd_ctrl_if.slave  bus
);
    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [3:0]        cmd_q;
    logic [2:0]        pt_x;
    logic [2:0]        pt_y;
    logic [DATA_W-1:0] buffer [64];

    logic [2:0]        xm1;
    logic [2:0]        ym1;
    logic [5:0]        a_tl, a_tr, a_bl, a_br;
    logic [DATA_W-1:0] p_tl, p_tr, p_bl, p_br;
    logic [DATA_W-1:0] mx_a, mx_b, mx_v;
    logic [DATA_W-1:0] mn_a, mn_b, mn_v;
    logic [DATA_W+1:0] sum;
    logic [DATA_W+1:0] avg_sum;
    logic [DATA_W-1:0] avg_v;
    logic [DATA_W-1:0] n_tl, n_tr, n_bl, n_br;
    logic              blk_we;

    // Block addressing and the new block contents for the latched command
    always_comb begin
        xm1  = pt_x - 3'd1;
        ym1  = pt_y - 3'd1;
        a_tl = {ym1, xm1};
        a_tr = {ym1, pt_x};
        a_bl = {pt_y, xm1};
        a_br = {pt_y, pt_x};
        p_tl = buffer[a_tl];
        p_tr = buffer[a_tr];
        p_bl = buffer[a_bl];
        p_br = buffer[a_br];

        mx_a = (p_tl > p_tr) ? p_tl : p_tr;
        mx_b = (p_bl > p_br) ? p_bl : p_br;
        mx_v = (mx_a > mx_b) ? mx_a : mx_b;
        mn_a = (p_tl < p_tr) ? p_tl : p_tr;
        mn_b = (p_bl < p_br) ? p_bl : p_br;
        mn_v = (mn_a < mn_b) ? mn_a : mn_b;

        sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
`ifdef LCD_AVG_ROUND_EN
        avg_sum = sum + 2;
`else
        avg_sum = sum;
`endif
        avg_v = avg_sum[DATA_W+1:2];

        n_tl   = p_tl;
        n_tr   = p_tr;
        n_bl   = p_bl;
        n_br   = p_br;
        blk_we = 1'b1;
        case (cmd_q)
            4'd5:    begin n_tl = mx_v;  n_tr = mx_v;  n_bl = mx_v;  n_br = mx_v;  end
            4'd6:    begin n_tl = mn_v;  n_tr = mn_v;  n_bl = mn_v;  n_br = mn_v;  end
            4'd7:    begin n_tl = avg_v; n_tr = avg_v; n_bl = avg_v; n_br = avg_v; end
            4'd8:    begin n_tl = p_tr;  n_tr = p_br;  n_br = p_bl;  n_bl = p_tl;  end
            4'd9:    begin n_tl = p_bl;  n_tr = p_tl;  n_br = p_tr;  n_bl = p_br;  end
            4'd10:   begin n_tl = p_bl;  n_bl = p_tl;  n_tr = p_br;  n_br = p_tr;  end
            4'd11:   begin n_tl = p_tr;  n_tr = p_tl;  n_bl = p_br;  n_br = p_bl;  end
            default: blk_we = 1'b0;
        endcase
    end

    // Image buffer: filled from the ROM during load, block-updated on EXEC
    always_ff @(posedge clk) begin
        if (state == S_LOAD && bus.IROM_rd) begin
            buffer[bus.IROM_A] <= bus.IROM_Q;
        end else if (state == S_EXEC && blk_we) begin
            buffer[a_tl] <= n_tl;
            buffer[a_tr] <= n_tr;
            buffer[a_bl] <= n_bl;
            buffer[a_br] <= n_br;
        end
    end

    // Control FSM: load, command handshake, operation point, write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_LOAD;
            cmd_q          <= 4'd0;
            pt_x           <= 3'(INIT_X);
            pt_y           <= 3'(INIT_Y);
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.IROM_rd    <= 1'b0;
            bus.IROM_A     <= 6'd0;
            bus.IRAM_valid <= 1'b0;
            bus.IRAM_A     <= 6'd0;
            bus.IRAM_D     <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    // First cycle only raises the read; later cycles capture and advance
                    if (!bus.IROM_rd) begin
                        bus.IROM_rd <= 1'b1;
                        bus.IROM_A  <= 6'd0;
                    end else if (bus.IROM_A == 6'd63) begin
                        bus.IROM_rd <= 1'b0;
                        bus.busy    <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        bus.IROM_A <= bus.IROM_A + 6'd1;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q    <= bus.cmd;
                        bus.busy <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cmd_q == 4'd0) begin
                        bus.IRAM_valid <= 1'b1;
                        bus.IRAM_A     <= 6'd0;
                        bus.IRAM_D     <= buffer[6'd0];
                        state          <= S_WRITE;
                    end else begin
                        case (cmd_q)
                            4'd1: if (pt_y != 3'd1) pt_y <= pt_y - 3'd1;
                            4'd2: if (pt_y != 3'd7) pt_y <= pt_y + 3'd1;
                            4'd3: if (pt_x != 3'd1) pt_x <= pt_x - 3'd1;
                            4'd4: if (pt_x != 3'd7) pt_x <= pt_x + 3'd1;
                            default: ;
                        endcase
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (bus.IRAM_A == 6'd63) begin
                        bus.IRAM_valid <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        bus.IRAM_A <= bus.IRAM_A + 6'd1;
                        bus.IRAM_D <= buffer[bus.IRAM_A + 6'd1];
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b1;
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl with ROM/RAM models and image reference model
module tb_lcd_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lcd_ctrl_if #(.DATA_W(8)) bus();

    lcd_ctrl #(.DATA_W(8), .INIT_X(4), .INIT_Y(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom [64];
    logic [7:0] ram [64];
    logic [7:0] img [64];
    int px, py;
    int pass_cnt = 0;
    int total_cnt = 0;
    int ram_writes;
    bit early_done, order_err;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] in_px;
        logic [31:0] ex_px;
    } vec_t;
    vec_t vecs [10];

    typedef struct {
        logic [3:0] pre;
        logic [3:0] dir;
        int         a0, a1, a2, a3;
        logic [7:0] val;
    } shift_t;
    shift_t shifts [4];

    // ROM answers on the falling edge after the address is presented
    always @(negedge clk) bus.IROM_Q <= rom[bus.IROM_A];

    // RAM model and write-back order / done-timing monitor
    always @(negedge clk) begin
        if (!reset) begin
            ram_writes = 0;
            early_done = 0;
            order_err  = 0;
        end else begin
            if (bus.IRAM_valid) begin
                if (bus.IRAM_A != 6'(ram_writes)) order_err = 1;
                ram[bus.IRAM_A] = bus.IRAM_D;
                ram_writes++;
            end
            if (bus.done && ram_writes < 64) early_done = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int addr(input int x, input int y);
        return y * 8 + x;
    endfunction

    task automatic model_load();
        for (int i = 0; i < 64; i++) img[i] = rom[i];
        px = 4;
        py = 4;
    endtask

    // Reference: block held as array [TL,TR,BL,BR]; permutations give new[i] = old[src[i]]
    task automatic model_cmd(input int c);
        int a [4];
        int v [4];
        int nv [4];
        int s, m;
        a[0] = addr(px - 1, py - 1); a[1] = addr(px, py - 1);
        a[2] = addr(px - 1, py);     a[3] = addr(px, py);
        for (int i = 0; i < 4; i++) v[i] = int'(img[a[i]]);
        for (int i = 0; i < 4; i++) nv[i] = v[i];
        case (c)
            1: if (py > 1) py--;
            2: if (py < 7) py++;
            3: if (px > 1) px--;
            4: if (px < 7) px++;
            5: begin m = v[0]; for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
                      for (int i = 0; i < 4; i++) nv[i] = m; end
            6: begin m = v[0]; for (int i = 1; i < 4; i++) if (v[i] < m) m = v[i];
                      for (int i = 0; i < 4; i++) nv[i] = m; end
            7: begin s = v[0] + v[1] + v[2] + v[3];
`ifdef LCD_AVG_ROUND_EN
                      m = (s + 2) / 4;
`else
                      m = s / 4;
`endif
                      for (int i = 0; i < 4; i++) nv[i] = m % 256; end
            8:  begin nv[0] = v[1]; nv[1] = v[3]; nv[2] = v[0]; nv[3] = v[2]; end
            9:  begin nv[0] = v[2]; nv[1] = v[0]; nv[2] = v[3]; nv[3] = v[1]; end
            10: begin nv[0] = v[2]; nv[1] = v[3]; nv[2] = v[0]; nv[3] = v[1]; end
            11: begin nv[0] = v[1]; nv[1] = v[0]; nv[2] = v[3]; nv[3] = v[2]; end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) img[a[i]] = 8'(nv[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_irom_rd"}, bus.IROM_rd, 0);
        chk({tag, "_irom_a"}, bus.IROM_A, 0);
        chk({tag, "_iram_valid"}, bus.IRAM_valid, 0);
        chk({tag, "_iram_a"}, bus.IRAM_A, 0);
        chk({tag, "_iram_d"}, bus.IRAM_D, 0);
    endtask

    task automatic do_load();
        int n;
        bit in_range;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_vals("rst");
        model_load();
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy === 1'b1 && n < 200);
        total_cnt++;
        in_range = (n >= 64 && n <= 66);
        if (in_range) pass_cnt++;
        else $display("FAIL load_busy_cycles: got %0d expected 64..66", n);
        chk("load_rd_low", bus.IROM_rd, 0);
    endtask

    task automatic issue(input logic [3:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("issue_timeout", n, 0);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        if (c != 4'd0) model_cmd(int'(c));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("busy_after_cmd", bus.busy, 1);
    endtask

    task automatic write_check();
        int n, bad;
        issue(4'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.done, 1);
        repeat (3) @(negedge clk);
        chk("done_not_early", early_done, 0);
        chk("ram_addr_order", order_err, 0);
        chk("ram_write_count", ram_writes, 64);
        chk("done_busy", bus.busy, 1);
        chk("iram_valid_off", bus.IRAM_valid, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== img[i]) bad++;
        chk("image_mismatches", bad, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int windows;
        bit prev_low, consec_err;

        vecs[0] = '{4'd5,  {8'd10, 8'd20, 8'd30, 8'd40}, {8'd40, 8'd40, 8'd40, 8'd40}};
        vecs[1] = '{4'd6,  {8'd10, 8'd20, 8'd30, 8'd40}, {8'd10, 8'd10, 8'd10, 8'd10}};
`ifdef LCD_AVG_ROUND_EN
        vecs[2] = '{4'd7,  {8'd1, 8'd2, 8'd2, 8'd2},     {8'd2, 8'd2, 8'd2, 8'd2}};
        vecs[9] = '{4'd7,  {8'd3, 8'd3, 8'd3, 8'd2},     {8'd3, 8'd3, 8'd3, 8'd3}};
`else
        vecs[2] = '{4'd7,  {8'd1, 8'd2, 8'd2, 8'd2},     {8'd1, 8'd1, 8'd1, 8'd1}};
        vecs[9] = '{4'd7,  {8'd3, 8'd3, 8'd3, 8'd2},     {8'd2, 8'd2, 8'd2, 8'd2}};
`endif
        vecs[3] = '{4'd8,  {8'd1, 8'd2, 8'd3, 8'd4},     {8'd2, 8'd4, 8'd1, 8'd3}};
        vecs[4] = '{4'd9,  {8'd1, 8'd2, 8'd3, 8'd4},     {8'd3, 8'd1, 8'd4, 8'd2}};
        vecs[5] = '{4'd10, {8'd1, 8'd2, 8'd3, 8'd4},     {8'd3, 8'd4, 8'd1, 8'd2}};
        vecs[6] = '{4'd11, {8'd1, 8'd2, 8'd3, 8'd4},     {8'd2, 8'd1, 8'd4, 8'd3}};
        vecs[7] = '{4'd13, {8'd1, 8'd2, 8'd3, 8'd4},     {8'd1, 8'd2, 8'd3, 8'd4}};
        vecs[8] = '{4'd7,  {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255}};

        shifts[0] = '{4'd3,  4'd1, 2, 3, 10, 11, 8'd11};
        shifts[1] = '{4'd3,  4'd2, 50, 51, 58, 59, 8'd59};
        shifts[2] = '{4'd13, 4'd3, 24, 25, 32, 33, 8'd33};
        shifts[3] = '{4'd13, 4'd4, 30, 31, 38, 39, 8'd39};

        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = 8'hxx;

        // Identity image load and write-back; commands after done are ignored
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        do_load();
        write_check();
        for (int i = 0; i < 64; i++) if (ram[i] !== 8'(i)) chk("identity_pixel", int'(ram[i]), i);
        @(negedge clk);
        bus.cmd = 4'd5;
        bus.cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("done_sticky", bus.done, 1);
        chk("done_busy_sticky", bus.busy, 1);
        chk("no_writes_after_done", ram_writes, 64);

        // Block commands at the reset operation point (4,4)
        foreach (vecs[k]) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'(i + 100);
            rom[27] = vecs[k].in_px[31:24];
            rom[28] = vecs[k].in_px[23:16];
            rom[35] = vecs[k].in_px[15:8];
            rom[36] = vecs[k].in_px[7:0];
            do_load();
            issue(vecs[k].cmd);
            write_check();
            chk($sformatf("vec%0d_tl", k), int'(ram[27]), int'(vecs[k].ex_px[31:24]));
            chk($sformatf("vec%0d_tr", k), int'(ram[28]), int'(vecs[k].ex_px[23:16]));
            chk($sformatf("vec%0d_bl", k), int'(ram[35]), int'(vecs[k].ex_px[15:8]));
            chk($sformatf("vec%0d_br", k), int'(ram[36]), int'(vecs[k].ex_px[7:0]));
        end

        // Shift saturation at each edge, then Max on the resulting block
        foreach (shifts[k]) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'(i);
            do_load();
            issue(shifts[k].pre);
            repeat (5) issue(shifts[k].dir);
            issue(4'd5);
            write_check();
            chk($sformatf("shift%0d_a0", k), int'(ram[shifts[k].a0]), int'(shifts[k].val));
            chk($sformatf("shift%0d_a1", k), int'(ram[shifts[k].a1]), int'(shifts[k].val));
            chk($sformatf("shift%0d_a2", k), int'(ram[shifts[k].a2]), int'(shifts[k].val));
            chk($sformatf("shift%0d_a3", k), int'(ram[shifts[k].a3]), int'(shifts[k].val));
        end

        // cmd_valid held high: one command per busy-low window
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        do_load();
        windows = 0;
        prev_low = 0;
        consec_err = 0;
        bus.cmd = 4'd13;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.busy === 1'b0) begin
                windows++;
                if (prev_low) consec_err = 1;
                prev_low = 1;
                bus.cmd = (windows == 4) ? 4'd3 : 4'd13;
                model_cmd(int'(bus.cmd));
            end else begin
                prev_low = 0;
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("hold_windows", windows, 10);
        chk("hold_single_cycle_windows", consec_err, 0);
        issue(4'd5);
        write_check();
        chk("hold_left_once_max", int'(ram[26]), 35);

        // Randomized command streams against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
            do_load();
            for (int j = 0; j < 25; j++) issue(4'($urandom_range(1, 15)));
            write_check();
        end

        // Reset in the middle of write-back restarts the load from address 0
        for (int i = 0; i < 64; i++) rom[i] = 8'(63 - i);
        do_load();
        issue(4'd0);
        repeat (20) @(negedge clk);
        chk("mid_write_valid", bus.IRAM_valid, 1);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_load();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_rd", bus.IROM_rd, 1);
        chk("reload_a0", bus.IROM_A, 0);
        @(posedge clk);
        #1;
        chk("reload_a1", bus.IROM_A, 1);
        write_check();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- 8x8 greyscale image processor, 8-bit pixels, 64 in total.
- After reset it loads the whole image from an external image ROM into an internal buffer.
- It then executes host commands on the 2x2 block surrounding a movable operation point.
- On the Write command it copies the buffer to an external image RAM and signals done.

Parameters:
- DATA_W, 8, pixel width in bits.
- INIT_X, 4, operation point column after reset (valid range 1..7).
- INIT_Y, 4, operation point row after reset (valid range 1..7).

Ports:
- clk  input  1  system clock; all DUT registers update on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd  input  4  command code; sampled when cmd_valid=1 and busy=0.
- cmd_valid  input  1  command strobe.
- IROM_rd  output  1  image ROM read enable.
- IROM_A  output  6  image ROM address.
- IROM_Q  input  8  image ROM data. The ROM updates it on the falling edge after the address is presented.
- IRAM_valid  output  1  image RAM write enable; the RAM writes on the falling edge.
- IRAM_A  output  6  image RAM address.
- IRAM_D  output  8  image RAM write data.
- busy  output  1  high = DUT not accepting commands.
- done  output  1  high = image write-back complete.

Behaviour:
- Addressing: pixel (x,y) with x = column, y = row, both 0..7; address = y*8 + x.
- Active block relative to operation point (X,Y): TL=(X-1,Y-1), TR=(X,Y-1), BL=(X-1,Y), BR=(X,Y).
- Reset values (asserted): state=LOAD, busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, X=INIT_X, Y=INIT_Y.
- Reset mid-operation aborts everything and returns to these values.
- States: LOAD, IDLE, EXEC, WRITE, DONE.
- LOAD:
  - IROM_rd=1; IROM_A steps 0..63, one address per cycle.
  - Data for address n is captured into buffer[n] on the rising edge after address n was driven.
  - After buffer[63] is captured: IROM_rd=0, busy=0, go to IDLE.
- IDLE:
  - On a rising edge with cmd_valid=1: latch cmd, set busy=1, go to EXEC.
  - busy must be high before the next falling edge so the host issues no second command.
- EXEC: one cycle. Apply the command, busy=0, return to IDLE. Write is the exception and goes to WRITE.
- Command codes:
  - 0 Write: go to WRITE.
  - 1 Shift Up: Y-1, unless Y=1.
  - 2 Shift Down: Y+1, unless Y=7.
  - 3 Shift Left: X-1, unless X=1.
  - 4 Shift Right: X+1, unless X=7.
  - At a boundary a shift is a no-op (saturate, no wrap).
  - 5 Max: all four block pixels := their maximum.
  - 6 Min: all four block pixels := their minimum.
  - 7 Average: all four := floor(sum/4). Sum uses a 10-bit accumulator; result truncated to 8 bits.
  - 8 Rotate CCW: TL:=TR, TR:=BR, BR:=BL, BL:=TL (simultaneous).
  - 9 Rotate CW: TL:=BL, TR:=TL, BR:=TR, BL:=BR.
  - 10 Mirror X: swap TL<->BL and TR<->BR.
  - 11 Mirror Y: swap TL<->TR and BL<->BR.
  - 12-15: no-op.
- Operation point is unaffected by codes 5-11.
- WRITE:
  - IRAM_valid=1; IRAM_A steps 0..63 with IRAM_D=buffer[IRAM_A], one pixel per cycle.
  - Address and data are driven from the rising edge so the RAM captures them on the falling edge.
  - After address 63: IRAM_valid=0, go to DONE.
- DONE:
  - done=1, asserted on the first rising edge after the last RAM write edge.
  - done and busy stay 1 until reset; further commands are ignored.

Optional Feature:
- Macro: LCD_AVG_ROUND_EN.
- Defined: Average result = floor((sum+2)/4), i.e. round to nearest, half-up.
- Undefined (default): Average result = floor(sum/4).
- No other behaviour differs.

Test Plan:
- Reset, then load a ROM holding value = address. Expect busy=1 for the whole load and busy=0 about 65 cycles after reset release. Then issue Write. Expect RAM[n]=n for all n, and done rising only after RAM[63] is written.
- Block at (4,4) = addresses 27,28,35,36 holding 10,20,30,40:
  - Max -> all 40.
  - Min -> all 10.
  - Average with values 1,2,2,2 -> all 1 (default); 2 with LCD_AVG_ROUND_EN.
- Block TL,TR,BL,BR = 1,2,3,4:
  - CCW -> 2,4,1,3.
  - CW -> 3,1,4,2.
  - Mirror X -> 3,4,1,2.
  - Mirror Y -> 2,1,4,3.
- Shift Up x5 then Max: point saturates at Y=1 and Max acts on addresses 2,3,10,11. Repeat for Down to Y=7 (addresses 50,51,58,59), and likewise for Left and Right.
- Hold cmd_valid=1 continuously: exactly one command is consumed per busy low window; cmd=13 leaves the image unchanged.
- Assert reset during WRITE: outputs return to reset values and loading restarts from IROM address 0.
